// File: rtl/serial_deser.sv
// serial_deser: serial-to-parallel deserializer, one bit per cycle in, WIDTH-bit words out
// Ports:
//   clock     - single clock, all state updates on posedge
//   reset     - asynchronous, active-low reset
//   in_valid  - in_bit is valid this cycle
//   in_bit    - serial data bit
//   in_ready  - block accepts a bit this cycle
//   flush     - synchronous discard of the partially assembled word
//   out_valid - out_data holds a complete word
//   out_data  - assembled word
//   out_ready - consumer takes the word this cycle
//   bit_count - bits held in the accumulator (WIDTH while a word waits in HOLD)
module serial_deser #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_bit,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam logic S_FILL = 1'b0;
    localparam logic S_HOLD = 1'b1;

    logic             state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             accept, xfer, last;
    logic [IW-1:0]    pos;
    logic [WIDTH-1:0] word;

    always_comb begin
        // reset gates in_ready so nothing is offered while the block is held in reset
        in_ready    = reset & (state_q == S_FILL) & !flush;
        accept      = in_valid & in_ready;
        xfer        = out_valid_q & out_ready;
        last        = cnt_q == CW'(WIDTH - 1);
        pos         = (MSB_FIRST != 0) ? IW'(CW'(WIDTH - 1) - cnt_q) : IW'(cnt_q);
        word        = acc_q;
        word[pos]   = in_bit;
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = xfer ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            state_d = S_FILL;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == S_HOLD) begin
            if (xfer) begin
                out_data_d  = acc_q;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                state_d     = S_FILL;
            end
        end else if (accept) begin
            if (!last) begin
                acc_d = word;
                cnt_d = cnt_q + CW'(1);
            end else if (!out_valid_q || out_ready) begin
                out_data_d  = word;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                // buffer still occupied: park the finished word in the accumulator
                acc_d   = word;
                cnt_d   = CW'(WIDTH);
                state_d = S_HOLD;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign bit_count = cnt_q;
endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed and randomized checks of serial_deser (WIDTH=8, both bit orders)
module tb_serial_deser;
    logic       clock = 1'b0;
    logic       reset, in_valid, in_bit, flush, out_ready;
    logic       in_ready, out_valid, in_ready1, out_valid1;
    logic [7:0] out_data, out_data1;
    logic [3:0] bit_count, bit_count1;
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    serial_deser #(.WIDTH(8), .MSB_FIRST(0)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .bit_count(bit_count));

    serial_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready1), .flush(flush), .out_valid(out_valid1),
        .out_data(out_data1), .out_ready(out_ready), .bit_count(bit_count1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    initial begin
        logic [7:0] stream;
        logic [7:0] words [4];
        logic [7:0] exp_q [$];
        logic [7:0] macc;
        logic [7:0] head;
        int mcnt, nsent, nrecv;

        reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // 1: 1,0,1,1,0,0,1,0 -> 4D (LSB first) / B2 (MSB first), one-cycle pulse
        stream = 8'b0100_1101;
        for (int i = 0; i < 7; i++) send_bit(stream[i]);
        chk("t1_no_early_valid", out_valid, 0);
        chk("t1_count7", bit_count, 7);
        send_bit(stream[7]);
        chk("t1_valid", out_valid, 1);
        chk("t1_data_lsb", out_data, 8'h4D);
        chk("t1_data_msb", out_data1, 8'hB2);
        chk("t1_count0", bit_count, 0);
        tick();
        chk("t1_pulse_end", out_valid, 0);
        chk("t1_data_hold", out_data, 8'h4D);

        // 2: backpressure, A5 waits in the buffer, 3C waits in HOLD
        out_ready = 1'b0;
        send_byte(8'hA5);
        chk("t2_a5_valid", out_valid, 1);
        chk("t2_a5_data", out_data, 8'hA5);
        send_byte(8'h3C);
        chk("t2_held_data", out_data, 8'hA5);
        chk("t2_held_valid", out_valid, 1);
        chk("t2_hold_in_ready", in_ready, 0);
        chk("t2_hold_count", bit_count, 8);
        tick();
        chk("t2_still_hold", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("t2_3c_data", out_data, 8'h3C);
        chk("t2_3c_valid", out_valid, 1);
        chk("t2_fill_in_ready", in_ready, 1);
        chk("t2_fill_count", bit_count, 0);
        tick();
        chk("t2_drained", out_valid, 0);

        // 3: partial word then flush, then a clean FF word
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("t3_count3", bit_count, 3);
        flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        #1;
        chk("t3_flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t3_flush_count", bit_count, 0);
        chk("t3_flush_no_valid", out_valid, 0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        chk("t3_no_early_word", out_valid, 0);
        send_bit(1'b1);
        chk("t3_ff_valid", out_valid, 1);
        chk("t3_ff_data", out_data, 8'hFF);
        tick();
        chk("t3_single_word", out_valid, 0);

        // 4: reset mid-word with a word pending
        out_ready = 1'b0;
        send_byte(8'h0F);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("t4_pre_count", bit_count, 5);
        chk("t4_pre_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        chk("t4_rst_valid", out_valid, 0);
        chk("t4_rst_data", out_data, 0);
        chk("t4_rst_count", bit_count, 0);
        chk("t4_rst_in_ready", in_ready, 0);
        reset = 1'b1; out_ready = 1'b1;
        send_byte(8'h5A);
        chk("t4_resume_data", out_data, 8'h5A);
        chk("t4_resume_valid", out_valid, 1);
        tick();

        // 5: 32 continuous bits, full rate
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56; words[3] = 8'h78;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_bit = words[i/8][i%8];
            #1;
            chk("t5_in_ready", in_ready, 1);
            tick();
            chk("t5_valid_cadence", out_valid, (i % 8 == 7) ? 1 : 0);
            if (i % 8 == 7) chk("t5_word", out_data, words[i/8]);
        end
        in_valid = 1'b0;
        tick();

        // 6: random gaps and backpressure against a reference model
        exp_q.delete();
        macc = '0; mcnt = 0; nsent = 0; nrecv = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_bit    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                head = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                chk("t6_word", out_data, head);
                nrecv++;
            end
            if (in_valid && in_ready) begin
                macc[mcnt] = in_bit;
                mcnt++;
                if (mcnt == 8) begin
                    exp_q.push_back(macc);
                    nsent++;
                    mcnt = 0;
                end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                head = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                chk("t6_drain_word", out_data, head);
                nrecv++;
            end
            tick();
        end
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_count_match", nrecv, nsent);
        chk("t6_partial_count", bit_count, mcnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
